fibonacci_checker: RTL

//   Receive-side companion to the Fibonacci generator: consumes a stream of words and checks

---
 rtl/fibonacci_checker.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/fibonacci_checker.sv
// fibonacci_checker: receive-side checker for a Fibonacci word stream.
// It verifies, beat by beat, that the stream follows F0=1, F1=1 and
// Fn = Fn-1 + Fn-2, with the sum taken mod 2^DATA_WIDTH.
// For each accepted beat it reports, one cycle later, the match flag, the
// expected term, the lock state, the current run length and the error count.
// Optional feature: define FIB_CHK_RESYNC_EN so that a mismatching beat of
// value 1 in TRACK is reused as F0 of a new run.
module fibonacci_checker #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  output logic                  out_match,
  output logic [DATA_WIDTH-1:0] out_expected,
  output logic                  locked,
  output logic [CNT_WIDTH-1:0]  run_len,
  output logic [CNT_WIDTH-1:0]  err_count
);

  // IDLE: waiting for F0; ONE: F0 seen, waiting for F1; TRACK: summing a+b.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ONE   = 2'd1,
    ST_TRACK = 2'd2
  } state_t;

  state_t                state_reg, state_next;
  logic [DATA_WIDTH-1:0] a_reg, a_next;
  logic [DATA_WIDTH-1:0] b_reg, b_next;
  logic [DATA_WIDTH-1:0] expected;
  logic                  beat_match;

  logic                  out_valid_reg;
  logic                  out_match_reg;
  logic [DATA_WIDTH-1:0] out_expected_reg;
  logic [CNT_WIDTH-1:0]  run_len_reg;
  logic [CNT_WIDTH-1:0]  err_count_reg;

  // Counters stop at all-ones instead of wrapping.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (v == {CNT_WIDTH{1'b1}}) ? v : v + CNT_WIDTH'(1);
  endfunction

  // State register together with the two most recent verified terms.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_reg <= ST_IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
    end else begin
      state_reg <= state_next;
      a_reg     <= a_next;
      b_reg     <= b_next;
    end
  end

  // Next-state logic; a and b only carry meaning while in TRACK.
  always_comb begin
    state_next = state_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    if (in_valid) begin
      case (state_reg)
        ST_IDLE: begin
          if (beat_match) begin
            state_next = ST_ONE;
            b_next     = DATA_WIDTH'(1);
          end
        end
        ST_ONE: begin
          if (beat_match) begin
            state_next = ST_TRACK;
            a_next     = DATA_WIDTH'(1);
            b_next     = DATA_WIDTH'(1);
          end else begin
            state_next = ST_IDLE;
          end
        end
        ST_TRACK: begin
          if (beat_match) begin
            a_next = b_reg;
            b_next = in_data;
          end else begin
`ifdef FIB_CHK_RESYNC_EN
            // A stray 1 may be the start of a fresh sequence: treat it as F0.
            if (in_data == DATA_WIDTH'(1)) begin
              state_next = ST_ONE;
              b_next     = DATA_WIDTH'(1);
            end else begin
              state_next = ST_IDLE;
            end
`else
            state_next = ST_IDLE;
`endif
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  // Expected term for the current beat; the carry out of a+b is dropped on purpose.
  always_comb begin
    expected   = (state_reg == ST_TRACK) ? (a_reg + b_reg) : DATA_WIDTH'(1);
    beat_match = (in_data == expected);
  end

  // Per-beat result registers and saturating run/error counters.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      out_valid_reg    <= 1'b0;
      out_match_reg    <= 1'b0;
      out_expected_reg <= '0;
      run_len_reg      <= '0;
      err_count_reg    <= '0;
    end else if (in_valid) begin
      out_valid_reg    <= 1'b1;
      out_match_reg    <= beat_match;
      out_expected_reg <= expected;
      if (beat_match) begin
        run_len_reg <= sat_inc(run_len_reg);
      end else begin
        run_len_reg   <= '0;
        err_count_reg <= sat_inc(err_count_reg);
      end
    end else begin
      out_valid_reg <= 1'b0;
    end
  end

  assign out_valid    = out_valid_reg;
  assign out_match    = out_match_reg;
  assign out_expected = out_expected_reg;
  assign run_len      = run_len_reg;
  assign err_count    = err_count_reg;
  // state_reg already holds the post-beat state, so lock tracks out_valid timing.
  assign locked       = (state_reg == ST_TRACK);

endmodule
